dcache_axi_write_bridge: RTL and testbench
==========================================

// Module: dcache_axi_write_bridge
// PURPOSE
//  Memory-side responder for the data-cache write buffer's line-write port (mem_wen/mem_awaddr/mem_wdata/mem_bvalid).
//  Captures one 256-bit dirty line and issues it as a single AXI3/4 INCR burst of 32-bit beats.
//  Returns a one-cycle mem_bvalid_o pulse to the write buffer after the AXI B response.
//  Sits between the write buffer and the AXI interconnect; one outstanding write at a time.
// PARAMETERS
//  LINE_WIDTH   256  cache line width in bits (one way-line)
//  AXI_DW       32   AXI data width; BEATS = LINE_WIDTH/AXI_DW = 8
//  AXI_ID       4'h1 fixed AWID value
// PORTS
//  clk              in   1    clock, all logic on rising edge
//  rst              in   1    asynchronous, active-low reset
//  mem_wen_i        in   1    write request from write buffer; level, held until mem_bvalid_o
//  mem_awaddr_i     in   32   line address (bits [4:0] ignored)
//  mem_wdata_i      in   256  line data; bits [31:0] = lowest word
//  mem_bvalid_o     out  1    one-cycle pulse: line committed to memory
//  mem_berr_o       out  1    one-cycle pulse with mem_bvalid_o when BRESP != OKAY
//  awid/awaddr      out  4/32 AXI AW id / line-aligned address {addr[31:5],5'b0}
//  awlen/awsize/awburst out 4/3/2 constant 7 / 3'b010 / 2'b01 (INCR)
//  awvalid          out  1    AW valid
//  awready          in   1    AW ready
//  wdata/wstrb      out  32/4 beat data / constant 4'hF
//  wlast/wvalid     out  1/1  last beat / W valid
//  wready           in   1    W ready
//  bresp/bvalid     in   2/1  B response / valid (bid ignored)
//  bready           out  1    B ready
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, beat_cnt=0, awvalid=wvalid=wlast=bready=0, mem_bvalid_o=mem_berr_o=0.
//  Reset mid-burst abandons the transaction; no completion pulse is produced.
//  FSM IDLE -> AW -> W -> B -> RESP -> IDLE. All AXI/handshake outputs are registered.
//  IDLE: if mem_wen_i=1, latch addr (aligned) and full line into local regs, awvalid<=1, go AW.
//        Upstream data changes after this edge are not observed for this burst.
//  AW: hold awvalid/awaddr stable until awready=1; on handshake awvalid<=0, wvalid<=1, beat_cnt=0, go W.
//  W: wdata = line[beat_cnt*32 +: 32]; wlast = (beat_cnt==7).
//     beat_cnt advances only on wvalid&wready; wdata/wlast stable while wready=0.
//     On handshake with wlast=1: wvalid<=0, bready<=1, go B.
//  B: on bvalid&bready: bready<=0, mem_bvalid_o<=1, mem_berr_o<=(bresp!=2'b00), go RESP.
//  RESP: pulses high exactly this one cycle; mem_wen_i is ignored here (the buffer drops it combinationally on bvalid).
//        Next state is IDLE.
//  IDLE samples mem_wen_i again the cycle after RESP, so a rewrite re-request costs one idle cycle minimum.
//  Minimum latency (all readies high): request edge -> mem_bvalid_o = 1 (AW) + 8 (W) + 1 (B) + 1 = 11 cycles.
//  awvalid and wvalid are never high together. bready is high only in B.
//  Error response is reported, not retried; the line is still considered written.
//  A beat count wrap past 7 is impossible: beat_cnt is reset in AW and the FSM leaves W on wlast.
// TESTING
//  Addr 0x1000_0013, data words 0..7 = 0xA0..0xA7, readies high -> awaddr=0x1000_0000, awlen=7,
//    wdata 0xA0..0xA7, wlast on 8th beat, mem_bvalid_o pulse 11 cycles after request.
//  awready held low 5 cycles -> awvalid and awaddr stable throughout; W phase starts the cycle after awready.
//  wready toggled 1/0 each cycle -> 8 accepted beats in order, no duplication or skip; wlast only on beat 7.
//  Upstream mem_wdata_i changed to 0xFF.. the cycle after capture -> the bus still carries the original 0xA0..0xA7.
//  bresp=2'b10 -> mem_bvalid_o and mem_berr_o both pulse one cycle; the next request proceeds normally.
//  rst asserted during beat 4 -> all outputs 0 immediately (async). After release, wen=1 starts a fresh AW with beat 0.

Source files
------------

// File: rtl/dcache_axi_write_bridge.sv
// Write-buffer line-write responder: captures one dirty cache line and issues it as a
// single AXI INCR burst, then returns a one-cycle completion (and error) pulse upstream.
module dcache_axi_write_bridge #(
    parameter int         LINE_WIDTH = 256,
    parameter int         AXI_DW     = 32,
    parameter logic [3:0] AXI_ID     = 4'h1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_wen_i,
    input  logic [31:0]           mem_awaddr_i,
    input  logic [LINE_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_bvalid_o,
    output logic                  mem_berr_o,
    output logic [3:0]            awid,
    output logic [31:0]           awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [AXI_DW-1:0]     wdata,
    output logic [AXI_DW/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int BEATS = LINE_WIDTH / AXI_DW;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0]      LINE_MASK = 32'(LINE_WIDTH / 8 - 1);
    localparam logic [CNT_W-1:0] PENULT    = CNT_W'(BEATS - 2);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AW   = 3'd1;
    localparam logic [2:0] W    = 3'd2;
    localparam logic [2:0] B    = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    logic [2:0]            state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [LINE_WIDTH-1:0] line;

    assign awid    = AXI_ID;
    assign awlen   = 4'(BEATS - 1);
    assign awsize  = 3'($clog2(AXI_DW / 8));
    assign awburst = 2'b01;
    assign wstrb   = '1;
    // The captured line is shifted down one beat per W handshake, so wdata is a flop output.
    assign wdata   = line[AXI_DW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            line         <= '0;
            awaddr       <= '0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            wlast        <= 1'b0;
            bready       <= 1'b0;
            mem_bvalid_o <= 1'b0;
            mem_berr_o   <= 1'b0;
        end else begin
            mem_bvalid_o <= 1'b0;
            mem_berr_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_wen_i) begin
                        awaddr  <= mem_awaddr_i & ~LINE_MASK;
                        line    <= mem_wdata_i;
                        awvalid <= 1'b1;
                        state   <= AW;
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        wvalid   <= 1'b1;
                        beat_cnt <= '0;
                        wlast    <= (BEATS == 1);
                        state    <= W;
                    end
                end
                W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            line     <= line >> AXI_DW;
                            wlast    <= (beat_cnt == PENULT);
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready       <= 1'b0;
                        mem_bvalid_o <= 1'b1;
                        mem_berr_o   <= (bresp != 2'b00);
                        state        <= RESP;
                    end
                end
                // Completion pulse is visible here; the request level is not looked at until IDLE.
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_write_bridge.sv
// Bench for dcache_axi_write_bridge: drives line-write requests with varied AXI ready/response
// timing and compares the observed bursts and completion pulses against a simple transaction model.
module tb_dcache_axi_write_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_wen_i = 1'b0;
    logic [31:0]  mem_awaddr_i = '0;
    logic [255:0] mem_wdata_i = '0;
    logic         mem_bvalid_o, mem_berr_o;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid;
    logic         wready = 1'b0;
    logic [1:0]   bresp = 2'b00;
    logic         bvalid = 1'b0;
    logic         bready;

    dcache_axi_write_bridge dut (
        .clk(clk), .rst(rst),
        .mem_wen_i(mem_wen_i), .mem_awaddr_i(mem_awaddr_i), .mem_wdata_i(mem_wdata_i),
        .mem_bvalid_o(mem_bvalid_o), .mem_berr_o(mem_berr_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by drive_txn
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    logic [31:0] obs_awaddr;
    logic        obs_berr;
    int obs_pulses, pulse_cyc, aw_hs_cyc, first_w_cyc;
    int aw_unstable, w_unstable, viol, aw_stalls, w_stalls;
    bit timed_out;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    // wmode: 0 = wready always high, 1 = toggles each cycle, 2 = random
    task automatic drive_txn(input logic [31:0] addr, input logic [255:0] line, input int aw_wait,
                             input int wmode, input int b_wait, input logic [1:0] resp, input bit corrupt);
        int cyc, end_cyc, bcnt;
        bit aw_seen, prev_stall;
        logic [31:0] first_awaddr, prev_wdata;
        logic prev_wlast;
        obs_data.delete(); obs_last.delete();
        obs_pulses = 0; pulse_cyc = -1; aw_hs_cyc = -1; first_w_cyc = -1; obs_berr = 1'b0;
        aw_unstable = 0; w_unstable = 0; viol = 0; aw_stalls = 0; w_stalls = 0; timed_out = 0;
        obs_awaddr = '0; first_awaddr = '0; prev_wdata = '0; prev_wlast = 1'b0;
        cyc = 0; end_cyc = 0; bcnt = 0; aw_seen = 0; prev_stall = 0;
        @(negedge clk);
        mem_wen_i = 1'b1; mem_awaddr_i = addr; mem_wdata_i = line;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = resp;
        while (end_cyc == 0 || cyc < end_cyc) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
            if (corrupt && cyc == 1) mem_wdata_i = '1;
            if (awvalid && wvalid) viol++;
            if (bready && (awvalid || wvalid)) viol++;
            if (mem_berr_o && !mem_bvalid_o) viol++;
            if (mem_bvalid_o) begin
                obs_pulses++;
                pulse_cyc = cyc;
                obs_berr  = mem_berr_o;
                mem_wen_i = 1'b0;
                if (end_cyc == 0) end_cyc = cyc + 3;
            end
            if (bready) begin
                if (bcnt >= b_wait) bvalid = 1'b1;
                else begin bvalid = 1'b0; bcnt++; end
            end else bvalid = 1'b0;
            if (awvalid) begin
                if (!aw_seen) begin first_awaddr = awaddr; aw_seen = 1; end
                else if (awaddr !== first_awaddr) aw_unstable++;
                awready = (aw_stalls >= aw_wait);
                if (!awready) aw_stalls++;
                else begin aw_hs_cyc = cyc; obs_awaddr = awaddr; end
            end else awready = 1'b0;
            if (wvalid) begin
                if (first_w_cyc < 0) first_w_cyc = cyc;
                if (prev_stall && (wdata !== prev_wdata || wlast !== prev_wlast)) w_unstable++;
                case (wmode)
                    0:       wready = 1'b1;
                    1:       wready = (cyc % 2 == 1);
                    default: wready = 1'($urandom_range(0, 1));
                endcase
                if (wready) begin
                    obs_data.push_back(wdata); obs_last.push_back(wlast); prev_stall = 0;
                end else begin
                    w_stalls++; prev_stall = 1; prev_wdata = wdata; prev_wlast = wlast;
                end
            end else begin
                wready = 1'b0; prev_stall = 0;
            end
        end
        mem_wen_i = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({awvalid, wvalid, wlast, bready, mem_bvalid_o, mem_berr_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {awvalid, wvalid, wlast, bready, mem_bvalid_o, mem_berr_o});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({awvalid, wvalid, bready, mem_bvalid_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 0000", {awvalid, wvalid, bready, mem_bvalid_o});
        end
    endtask

    task automatic test_basic();
        logic [255:0] line;
        for (int i = 0; i < 8; i++) line[i*32 +: 32] = 32'hA0 + 32'(i);
        drive_txn(32'h1000_0013, line, 0, 0, 0, 2'b00, 0);
        n_checks++;
        if (obs_awaddr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL basic_awaddr: got %h expected 10000000", obs_awaddr);
        end
        n_checks++;
        if ({awid, awlen, awsize, awburst, wstrb} !== {4'h1, 4'd7, 3'b010, 2'b01, 4'hF}) begin
            n_fail++; $display("FAIL basic_awconst: got %h/%0d/%b/%b/%h expected 1/7/010/01/f", awid, awlen, awsize, awburst, wstrb);
        end
        n_checks++;
        if (obs_data.size() != 8) begin
            n_fail++; $display("FAIL basic_beats: got %0d expected 8", obs_data.size());
        end
        for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
            n_checks++;
            if ({obs_data[i], obs_last[i]} !== {line[i*32 +: 32], 1'(i == 7)}) begin
                n_fail++; $display("FAIL basic_beat%0d: got %h last %b expected %h last %b", i, obs_data[i], obs_last[i], line[i*32 +: 32], (i == 7));
            end
        end
        n_checks++;
        if (pulse_cyc != 11 || obs_pulses != 1 || obs_berr !== 1'b0 || timed_out) begin
            n_fail++; $display("FAIL basic_resp: got cycle %0d pulses %0d berr %b expected 11 1 0", pulse_cyc, obs_pulses, obs_berr);
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL basic_protocol: got %0d violations expected 0", viol);
        end
    endtask

    task automatic test_aw_stall();
        logic [255:0] line = rand_line();
        drive_txn(32'h2345_678C, line, 5, 0, 0, 2'b00, 0);
        n_checks++;
        if (aw_unstable != 0 || obs_awaddr !== 32'h2345_6780) begin
            n_fail++; $display("FAIL aw_stall_stable: got %0d changes addr %h expected 0 23456780", aw_unstable, obs_awaddr);
        end
        n_checks++;
        if (first_w_cyc != aw_hs_cyc + 1 || aw_hs_cyc != 6) begin
            n_fail++; $display("FAIL aw_stall_wstart: got aw %0d w %0d expected 6 7", aw_hs_cyc, first_w_cyc);
        end
        n_checks++;
        if (pulse_cyc != 16 || obs_pulses != 1) begin
            n_fail++; $display("FAIL aw_stall_latency: got %0d pulses %0d expected 16 1", pulse_cyc, obs_pulses);
        end
    endtask

    task automatic test_w_toggle();
        logic [255:0] line = rand_line();
        int bad = 0;
        drive_txn(32'h0000_4040, line, 0, 1, 0, 2'b00, 0);
        for (int i = 0; i < obs_data.size(); i++)
            if ({obs_data[i], obs_last[i]} !== {line[i*32 +: 32], 1'(i == 7)}) bad++;
        n_checks++;
        if (obs_data.size() != 8 || bad != 0) begin
            n_fail++; $display("FAIL w_toggle_beats: got %0d beats %0d wrong expected 8 0", obs_data.size(), bad);
        end
        n_checks++;
        if (w_unstable != 0 || w_stalls == 0) begin
            n_fail++; $display("FAIL w_toggle_stable: got %0d changes over %0d stalls expected 0 over >0", w_unstable, w_stalls);
        end
        n_checks++;
        if (pulse_cyc != 11 + w_stalls) begin
            n_fail++; $display("FAIL w_toggle_latency: got %0d expected %0d", pulse_cyc, 11 + w_stalls);
        end
    endtask

    task automatic test_capture();
        logic [255:0] line;
        int bad = 0;
        for (int i = 0; i < 8; i++) line[i*32 +: 32] = 32'hA0 + 32'(i);
        drive_txn(32'h1000_0020, line, 2, 1, 1, 2'b00, 1);
        for (int i = 0; i < obs_data.size(); i++)
            if (obs_data[i] !== line[i*32 +: 32]) bad++;
        n_checks++;
        if (obs_data.size() != 8 || bad != 0) begin
            n_fail++; $display("FAIL capture_data: got %0d beats %0d wrong expected 8 0", obs_data.size(), bad);
        end
    endtask

    task automatic test_error_resp();
        logic [255:0] line = rand_line();
        drive_txn(32'h0BAD_0000, line, 0, 0, 2, 2'b10, 0);
        n_checks++;
        if (obs_pulses != 1 || obs_berr !== 1'b1 || viol != 0) begin
            n_fail++; $display("FAIL err_pulse: got pulses %0d berr %b viol %0d expected 1 1 0", obs_pulses, obs_berr, viol);
        end
        n_checks++;
        if (pulse_cyc != 13) begin
            n_fail++; $display("FAIL err_latency: got %0d expected 13", pulse_cyc);
        end
        line = rand_line();
        drive_txn(32'h0BAD_0040, line, 0, 0, 0, 2'b00, 0);
        n_checks++;
        if (obs_pulses != 1 || obs_berr !== 1'b0 || obs_data.size() != 8 || obs_data[0] !== line[31:0]) begin
            n_fail++; $display("FAIL err_next: got pulses %0d berr %b beats %0d expected 1 0 8", obs_pulses, obs_berr, obs_data.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [255:0] line = rand_line();
            logic [31:0]  addr = $urandom();
            logic [1:0]   resp = 2'($urandom_range(0, 3));
            int aw_w = $urandom_range(0, 3);
            int b_w  = $urandom_range(0, 3);
            int bad  = 0;
            drive_txn(addr, line, aw_w, 2, b_w, resp, 1'($urandom_range(0, 1)));
            for (int i = 0; i < obs_data.size(); i++)
                if ({obs_data[i], obs_last[i]} !== {line[i*32 +: 32], 1'(i == 7)}) bad++;
            n_checks++;
            if (obs_data.size() != 8 || bad != 0 || obs_awaddr !== {addr[31:5], 5'b0}) begin
                n_fail++; $display("FAIL rand%0d_burst: got %0d beats %0d wrong addr %h expected 8 0 %h", t, obs_data.size(), bad, obs_awaddr, {addr[31:5], 5'b0});
            end
            n_checks++;
            if (obs_pulses != 1 || obs_berr !== (resp != 2'b00) || pulse_cyc != 11 + aw_w + w_stalls + b_w || viol != 0 || w_unstable != 0) begin
                n_fail++; $display("FAIL rand%0d_resp: got pulses %0d berr %b cyc %0d viol %0d expected 1 %b %0d 0", t, obs_pulses, obs_berr, pulse_cyc, viol, (resp != 2'b00), 11 + aw_w + w_stalls + b_w);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] line = rand_line();
        int hs = 0;
        int cyc = 0;
        int stray = 0;
        @(negedge clk);
        mem_wen_i = 1'b1; mem_awaddr_i = 32'h3000_0000; mem_wdata_i = line;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (wvalid) begin
                if (hs == 4) break;
                hs++;
            end
        end
        n_checks++;
        if (hs != 4 || wdata !== line[4*32 +: 32]) begin
            n_fail++; $display("FAIL rst_mid_beat4: got beat %0d data %h expected 4 %h", hs, wdata, line[4*32 +: 32]);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({awvalid, wvalid, wlast, bready, mem_bvalid_o, mem_berr_o} !== 6'b0 || awaddr !== 32'h0 || wdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %b addr %h data %h expected 000000 0 0", {awvalid, wvalid, wlast, bready, mem_bvalid_o, mem_berr_o}, awaddr, wdata);
        end
        mem_wen_i = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (mem_bvalid_o || awvalid || wvalid) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL rst_mid_no_pulse: got %0d active cycles expected 0", stray);
        end
        line = rand_line();
        drive_txn(32'h3000_0040, line, 0, 0, 0, 2'b00, 0);
        n_checks++;
        if (obs_data.size() != 8 || obs_data[0] !== line[31:0] || obs_data[7] !== line[255:224] || obs_pulses != 1 || pulse_cyc != 11) begin
            n_fail++; $display("FAIL rst_mid_fresh: got %0d beats first %h pulses %0d cyc %0d expected 8 %h 1 11", obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'h0, obs_pulses, pulse_cyc, line[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_stall();
        test_w_toggle();
        test_capture();
        test_error_resp();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
